mpmc11_fifo_reader: RTL and testbench



---
 rtl/mpmc11_pkg.sv | 32 +++
 rtl/mpmc11_fifo_reader_if.sv | 42 ++++
 rtl/mpmc11_rdr_backoff.sv | 33 +++
 rtl/mpmc11_fifo_reader.sv | 147 ++++++++++++++
 tb/tb_mpmc11_fifo_reader.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpmc11_pkg.sv
// mpmc11_pkg: shared types and constants for the MPMC11 request FIFO reader.
//   mpmc11_fifoe_t      : one request entry as stored in the upstream FIFO
//   mpmc11_rdr_state_t  : reader state (idle / holding a request / backing off)
//   MPMC11_RDR_RETRY_W  : width of the replay counter
//   sat_inc16()         : 16-bit saturating increment used by the optional stats
package mpmc11_pkg;

   localparam int MPMC11_RDR_RETRY_W = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  id;
      logic        we;
   } mpmc11_fifoe_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_BACKOFF = 2'd2
   } mpmc11_rdr_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      logic [15:0] r;
      if (v == 16'hFFFF) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mpmc11_fifo_reader_if.sv
// mpmc11_fifo_reader_if: FIFO-side and controller-side signals of the reader.
//   fifo_valid/fifo_dout/fifo_rd : FWFT read port of the upstream request FIFO
//   req_valid/req/req_ready/rty  : held request towards the memory controller
//   err/retry_cnt/busy           : status
//   acc_cnt/rty_cnt              : only when MPMC11_RDR_STATS_EN is defined
// master = the reader, slave = its environment.
interface mpmc11_fifo_reader_if;

   logic                             fifo_valid;
   mpmc11_pkg::mpmc11_fifoe_t        fifo_dout;
   logic                             fifo_rd;
   logic                             req_valid;
   mpmc11_pkg::mpmc11_fifoe_t        req;
   logic                             req_ready;
   logic                             rty;
   logic                             err;
   logic [mpmc11_pkg::MPMC11_RDR_RETRY_W-1:0] retry_cnt;
   logic                             busy;
`ifdef MPMC11_RDR_STATS_EN
   logic [15:0]                      acc_cnt;
   logic [15:0]                      rty_cnt;

   modport master (
      input  fifo_valid, fifo_dout, req_ready, rty,
      output fifo_rd, req_valid, req, err, retry_cnt, busy, acc_cnt, rty_cnt
   );
   modport slave (
      output fifo_valid, fifo_dout, req_ready, rty,
      input  fifo_rd, req_valid, req, err, retry_cnt, busy, acc_cnt, rty_cnt
   );
`else
   modport master (
      input  fifo_valid, fifo_dout, req_ready, rty,
      output fifo_rd, req_valid, req, err, retry_cnt, busy
   );
   modport slave (
      output fifo_valid, fifo_dout, req_ready, rty,
      input  fifo_rd, req_valid, req, err, retry_cnt, busy
   );
`endif

endinterface

// File: rtl/mpmc11_rdr_backoff.sv
// mpmc11_rdr_backoff: 4-bit loadable down-counter timing the replay backoff.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one, sticking at zero
//   done       : counter is zero
module mpmc11_rdr_backoff (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       done
);

   logic [3:0] cnt_r;

   // Down-counter: load wins, decrement stops at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 4'd0;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != 4'd0)) begin
         cnt_r <= cnt_r - 4'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign done = (cnt_r == 4'd0);

endmodule

// File: rtl/mpmc11_fifo_reader.sv
// mpmc11_fifo_reader: pops requests from an FWFT FIFO, holds each one towards
// the memory controller, and replays it after a backoff when the controller
// answers rty. A request still rejected after RETRY_MAX replays is dropped
// with a one-cycle err pulse.
//   clk, rst_n : clock (FIFO read clock), asynchronous active-low reset
//   bus        : mpmc11_fifo_reader_if.master (FIFO port, request port, status)
// Optional feature: define MPMC11_RDR_STATS_EN to add the saturating
// acc_cnt / rty_cnt statistics outputs.
module mpmc11_fifo_reader
   import mpmc11_pkg::*;
#(
   parameter int RETRY_MAX = 7,
   parameter int BACKOFF   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mpmc11_fifo_reader_if.master bus
);

   localparam logic [MPMC11_RDR_RETRY_W-1:0] RETRY_MAX_C = 4'(RETRY_MAX);
   localparam logic [3:0]                    BO_LOAD_C   = 4'(BACKOFF - 1);

   mpmc11_rdr_state_t               state_r;
   mpmc11_fifoe_t                   req_r;
   logic                            req_valid_r;
   logic                            busy_r;
   logic                            err_r;
   logic [MPMC11_RDR_RETRY_W-1:0]   retry_cnt_r;

   logic accept_s;
   logic retry_s;
   logic pop_s;
   logic bo_load_s;
   logic bo_dec_s;
   logic bo_done_s;

   assign accept_s  = (state_r == ST_HOLD) && bus.req_ready && !bus.rty;
   assign retry_s   = (state_r == ST_HOLD) && bus.req_ready && bus.rty;
   // The pop must coincide with the capture edge, so it is decoded from the
   // current state; rst_n gates it so nothing is popped while in reset.
   assign pop_s     = rst_n && bus.fifo_valid &&
                      ((state_r == ST_IDLE) || accept_s);
   assign bo_load_s = retry_s && (retry_cnt_r != RETRY_MAX_C);
   assign bo_dec_s  = (state_r == ST_BACKOFF);

   mpmc11_rdr_backoff u_backoff (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (bo_load_s),
      .load_val (BO_LOAD_C),
      .dec      (bo_dec_s),
      .done     (bo_done_s)
   );

   // Reader FSM with registered request, status and error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         req_r       <= '0;
         req_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         err_r       <= 1'b0;
         retry_cnt_r <= 4'd0;
      end else begin
         err_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (pop_s) begin
                  req_r       <= bus.fifo_dout;
                  state_r     <= ST_HOLD;
                  req_valid_r <= 1'b1;
                  busy_r      <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (bus.req_ready) begin
                  if (!bus.rty) begin
                     retry_cnt_r <= 4'd0;
                     if (pop_s) begin
                        // back-to-back: next entry follows without a bubble
                        req_r <= bus.fifo_dout;
                     end else begin
                        state_r     <= ST_IDLE;
                        req_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                     end
                  end else if (retry_cnt_r != RETRY_MAX_C) begin
                     retry_cnt_r <= retry_cnt_r + 4'd1;
                     state_r     <= ST_BACKOFF;
                     req_valid_r <= 1'b0;
                  end else begin
                     // replay budget exhausted: drop the request
                     err_r       <= 1'b1;
                     retry_cnt_r <= 4'd0;
                     state_r     <= ST_IDLE;
                     req_valid_r <= 1'b0;
                     busy_r      <= 1'b0;
                  end
               end
            end
            ST_BACKOFF: begin
               if (bo_done_s) begin
                  state_r     <= ST_HOLD;
                  req_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               req_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               retry_cnt_r <= 4'd0;
            end
         endcase
      end
   end

   assign bus.fifo_rd   = pop_s;
   assign bus.req_valid = req_valid_r;
   assign bus.req       = req_r;
   assign bus.err       = err_r;
   assign bus.retry_cnt = retry_cnt_r;
   assign bus.busy      = busy_r;

`ifdef MPMC11_RDR_STATS_EN
   logic [15:0] acc_cnt_r;
   logic [15:0] rty_cnt_r;

   // Saturating accept and retry-response statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_cnt_r <= 16'd0;
         rty_cnt_r <= 16'd0;
      end else begin
         if (accept_s) begin
            acc_cnt_r <= sat_inc16(acc_cnt_r);
         end
         if (retry_s) begin
            rty_cnt_r <= sat_inc16(rty_cnt_r);
         end
      end
   end

   assign bus.acc_cnt = acc_cnt_r;
   assign bus.rty_cnt = rty_cnt_r;
`endif

endmodule

// File: tb/tb_mpmc11_fifo_reader.sv
// tb_mpmc11_fifo_reader: directed bench for mpmc11_fifo_reader with a
// transaction-level model checked every cycle plus hand-computed literals.
module tb_mpmc11_fifo_reader;
   import mpmc11_pkg::*;

   localparam int RETRY_MAX = 7;
   localparam int BACKOFF   = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   mpmc11_fifo_reader_if b ();

   mpmc11_fifo_reader #(.RETRY_MAX(RETRY_MAX), .BACKOFF(BACKOFF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b)
   );

   int n_vec = 0;
   int n_bad = 0;

   // environment: FIFO contents and controller response policy
   mpmc11_fifoe_t fifo_q[$];
   bit ctl_ready = 1'b0;
   int rty_left  = 0;
   bit pop_seen  = 1'b0;

   // model: the request the reader should be holding and its replay history
   bit            m_hold = 1'b0;
   mpmc11_fifoe_t m_req  = '0;
   int            m_rcnt = 0;
   int            m_bo   = 0;
   bit            m_err  = 1'b0;
   int            m_acc  = 0;
   int            m_rty  = 0;
   bit            exp_rv;
   bit            exp_rd;

   // per-scenario observation logs
   int n_pop, n_err, low_run, rd_run, max_rd_run, cyc, first_rd, first_rv;
   int prev_rc = 0;
   int acc_log[$];
   int rc_log[$];
   int low_log[$];
   int rty_base;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic int q_at(input int q[$], input int i);
      int r;
      if (i < q.size()) r = q[i];
      else r = -1;
      return r;
   endfunction

   function automatic mpmc11_fifoe_t mk(input int id);
      mpmc11_fifoe_t e;
      e.addr = 32'h1000_0000 + 32'(id) * 32'd16;
      e.id   = 4'(id);
      e.we   = 1'(id & 1);
      return e;
   endfunction

   function automatic void drive();
      b.fifo_valid = (fifo_q.size() > 0);
      b.fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      b.req_ready  = ctl_ready;
      b.rty        = ctl_ready && (rty_left > 0);
   endfunction

   function automatic void push(input int id);
      fifo_q.push_back(mk(id));
      drive();
   endfunction

   function automatic void clear_logs();
      n_pop = 0; n_err = 0; low_run = 0; rd_run = 0; max_rd_run = 0;
      cyc = 0; first_rd = -1; first_rv = -1;
      acc_log.delete(); rc_log.delete(); low_log.delete();
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (pop_seen && fifo_q.size() > 0) fifo_q.delete(0);
         drive();
      end
   endtask

   // compare process: checks the DUT against the model, then advances the model
   always @(negedge clk) begin
      if (!rst_n) begin
         m_hold = 1'b0; m_req = '0; m_rcnt = 0; m_bo = 0; m_err = 1'b0;
         m_acc = 0; m_rty = 0; pop_seen = 1'b0; prev_rc = 0; low_run = 0; rd_run = 0;
      end else begin
         exp_rv = m_hold && (m_bo == 0);
         exp_rd = b.fifo_valid && (!m_hold || (exp_rv && b.req_ready && !b.rty));
         chk("req_valid", b.req_valid, exp_rv);
         chk("busy", b.busy, m_hold);
         chk("fifo_rd", b.fifo_rd, exp_rd);
         chk("err", b.err, m_err);
         chk("retry_cnt", b.retry_cnt, m_rcnt);
         if (exp_rv) chk("req", b.req, m_req);
`ifdef MPMC11_RDR_STATS_EN
         chk("acc_cnt", b.acc_cnt, m_acc);
         chk("rty_cnt", b.rty_cnt, m_rty);
`endif
         // observation logs
         cyc++;
         if (b.fifo_rd) begin
            n_pop++; rd_run++;
            if (rd_run > max_rd_run) max_rd_run = rd_run;
            if (first_rd < 0) first_rd = cyc;
         end else begin
            rd_run = 0;
         end
         if (b.req_valid && first_rv < 0) first_rv = cyc;
         if (b.req_valid && b.req_ready && !b.rty) acc_log.push_back(int'(b.req.id));
         if (b.err) n_err++;
         if (int'(b.retry_cnt) != prev_rc) begin
            rc_log.push_back(int'(b.retry_cnt));
            prev_rc = int'(b.retry_cnt);
         end
         if (b.busy && !b.req_valid) low_run++;
         else if (low_run > 0) begin
            low_log.push_back(low_run);
            low_run = 0;
         end
         pop_seen = b.fifo_rd;
         // model step for the coming edge
         m_err = 1'b0;
         if (!m_hold) begin
            if (b.fifo_valid) begin
               m_hold = 1'b1;
               m_req  = b.fifo_dout;
            end
         end else if (m_bo > 0) begin
            m_bo--;
         end else if (b.req_ready) begin
            if (!b.rty) begin
               m_rcnt = 0;
               m_acc++;
               if (b.fifo_valid) m_req = b.fifo_dout;
               else m_hold = 1'b0;
            end else begin
               m_rty++;
               if (rty_left > 0) rty_left--;
               if (m_rcnt < RETRY_MAX) begin
                  m_rcnt++;
                  m_bo = BACKOFF;
               end else begin
                  m_err  = 1'b1;
                  m_rcnt = 0;
                  m_hold = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      drive();
      clear_logs();
      // reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", b.busy, 1'b0);
      chk("rst_req_valid", b.req_valid, 1'b0);
      chk("rst_fifo_rd", b.fifo_rd, 1'b0);
      chk("rst_retry_cnt", b.retry_cnt, 4'd0);
      chk("rst_req", b.req, '0);
      tick(3);
      rst_n = 1'b1;

      // single entry: pop, present one cycle later, accept, back to idle
      ctl_ready = 1'b1; drive();
      clear_logs();
      push(1);
      tick(5);
      chk("s1_acc_n", acc_log.size(), 1);
      chk("s1_acc0", q_at(acc_log, 0), 1);
      chk("s1_pops", n_pop, 1);
      chk("s1_latency", first_rv - first_rd, 1);
      chk("s1_busy", b.busy, 1'b0);

      // three back-to-back accepts in FIFO order
      clear_logs();
      push(2); push(3); push(4);
      tick(8);
      chk("s2_acc_n", acc_log.size(), 3);
      chk("s2_acc0", q_at(acc_log, 0), 2);
      chk("s2_acc1", q_at(acc_log, 1), 3);
      chk("s2_acc2", q_at(acc_log, 2), 4);
      chk("s2_rd_run", max_rd_run, 3);

      // two replays then accept
      clear_logs();
      rty_left = 2;
      push(5);
      tick(20);
      chk("s3_acc", q_at(acc_log, 0), 5);
      chk("s3_pops", n_pop, 1);
      chk("s3_rc_n", rc_log.size(), 3);
      chk("s3_rc0", q_at(rc_log, 0), 1);
      chk("s3_rc1", q_at(rc_log, 1), 2);
      chk("s3_rc2", q_at(rc_log, 2), 0);
      chk("s3_low_n", low_log.size(), 2);
      chk("s3_low0", q_at(low_log, 0), 4);
      chk("s3_low1", q_at(low_log, 1), 4);

      // every response rty: drop after RETRY_MAX replays, then next entry
      clear_logs();
`ifdef MPMC11_RDR_STATS_EN
      rty_base = int'(b.rty_cnt);
`endif
      rty_left = 8;
      push(6); push(7);
      tick(80);
      chk("s4_err_n", n_err, 1);
      chk("s4_acc_n", acc_log.size(), 1);
      chk("s4_acc0", q_at(acc_log, 0), 7);
      chk("s4_pops", n_pop, 2);
      chk("s4_rc_n", rc_log.size(), 8);
      chk("s4_rc6", q_at(rc_log, 6), 7);
      chk("s4_rty_left", rty_left, 0);
`ifdef MPMC11_RDR_STATS_EN
      chk("s4_rty_cnt", int'(b.rty_cnt) - rty_base, 8);
`endif

      // controller stalls with B waiting in the FIFO
      clear_logs();
      ctl_ready = 1'b0; drive();
      push(8); push(9);
      tick(10);
      chk("s5_pops", n_pop, 1);
      chk("s5_acc_n", acc_log.size(), 0);
      chk("s5_fifo_left", fifo_q.size(), 1);
      chk("s5_req_id", b.req.id, 4'd8);
      ctl_ready = 1'b1; drive();
      tick(5);
      chk("s5_acc_n2", acc_log.size(), 2);
      chk("s5_acc0", q_at(acc_log, 0), 8);
      chk("s5_acc1", q_at(acc_log, 1), 9);

      // reset during backoff, then the next entry is presented normally
      clear_logs();
      rty_left = 1;
      push(10);
      tick(2);
      push(11);
      tick(1);
      chk("s6_busy_bo", b.busy, 1'b1);
      chk("s6_rv_bo", b.req_valid, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("s6_rst_busy", b.busy, 1'b0);
      chk("s6_rst_rv", b.req_valid, 1'b0);
      chk("s6_rst_rd", b.fifo_rd, 1'b0);
      chk("s6_rst_rc", b.retry_cnt, 4'd0);
      chk("s6_rst_err", b.err, 1'b0);
      chk("s6_rst_req", b.req, '0);
      tick(2);
      rst_n = 1'b1;
      clear_logs();
      tick(6);
      chk("s6_acc_n", acc_log.size(), 1);
      chk("s6_acc0", q_at(acc_log, 0), 11);
      chk("s6_pops", n_pop, 1);
      chk("s6_fifo_empty", fifo_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
